// File: rtl/wb_arb2_bram.sv
// Two-master Wishbone arbiter in front of the BlockRAM slave: round-robin grant
// held for a whole bus cycle, plus a watchdog that errors a transfer the slave never acks.
module wb_arb2_bram #(
  parameter int unsigned timeout   = 255,
  parameter int unsigned tmo_width = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [tmo_width-1:0] TMO_LIMIT = tmo_width'(timeout);
  localparam bit                   WD_ON     = (timeout != 0);

  state_t               state, state_nxt;
  logic                 last_gnt;
  logic [tmo_width-1:0] wd_cnt, wd_nxt;
  logic                 wd_fire;

  logic                 g_cyc, g_stb, g_we;
  logic [31:0]          g_adr, g_dat;
  logic [3:0]           g_sel;

  // last_gnt only matters for the tie in IDLE; it names the master that must yield
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wd_cnt   <= '0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_nxt;
      if (state_nxt == GNT0 && state != GNT0)
        last_gnt <= 1'b0;
      else if (state_nxt == GNT1 && state != GNT1)
        last_gnt <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          state_nxt = last_gnt ? GNT0 : GNT1;
        else if (m0_cyc_i)
          state_nxt = GNT0;
        else if (m1_cyc_i)
          state_nxt = GNT1;
      end
      GNT0: if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    if (state == GNT0) begin
      g_cyc = m0_cyc_i;
      g_stb = m0_stb_i;
      g_we  = m0_we_i;
      g_adr = m0_adr_i;
      g_dat = m0_dat_i;
      g_sel = m0_sel_i;
    end else if (state == GNT1) begin
      g_cyc = m1_cyc_i;
      g_stb = m1_stb_i;
      g_we  = m1_we_i;
      g_adr = m1_adr_i;
      g_dat = m1_dat_i;
      g_sel = m1_sel_i;
    end
  end

  // The firing cycle itself masks stb and swallows any late ack, so err never meets ack
  assign wd_fire = WD_ON && g_cyc && g_stb && (wd_cnt == TMO_LIMIT);

  always_comb begin
    wd_nxt = '0;
    if (WD_ON && g_cyc && g_stb && !s_ack_i && !wd_fire && state_nxt == state)
      wd_nxt = wd_cnt + 1'b1;
  end

  assign s_cyc_o = g_cyc;
  assign s_stb_o = g_stb & ~wd_fire;
  assign s_we_o  = g_we;
  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;

  assign m0_ack_o = (state == GNT0) && s_ack_i && !wd_fire;
  assign m1_ack_o = (state == GNT1) && s_ack_i && !wd_fire;
  assign m0_err_o = (state == GNT0) && wd_fire;
  assign m1_err_o = (state == GNT1) && wd_fire;
  assign m0_dat_o = (state == GNT0) ? s_dat_i : 32'h0;
  assign m1_dat_o = (state == GNT1) ? s_dat_i : 32'h0;

endmodule

// File: tb/tb_wb_arb2_bram.sv
// Bench for wb_arb2_bram: per-cycle vector table for grant/mux behaviour, then
// hand sequences for round-robin bursts, handover, watchdog and reset.
module tb_wb_arb2_bram;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [31:0] m0_adr, m0_dat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [31:0] m1_adr, m1_dat, m1_rdat;
  logic [3:0]  m1_sel;

  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;

  logic        direct, d_ack;
  logic [31:0] d_dat;
  logic        bram_ack;
  logic [31:0] bram_rdat;
  logic [31:0] mem [1024];

  logic        z_cyc, z_stb;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
  logic [31:0] z_m0_rdat, z_m1_rdat;
  logic        z_s_cyc, z_s_stb, z_s_we;
  logic [31:0] z_s_adr, z_s_wdat;
  logic [3:0]  z_s_sel;

  int checks = 0;
  int errors = 0;
  int order_q[$];
  int both_ack = 0;
  bit bursts_done;

  always #5 clk = ~clk;

  wb_arb2_bram #(.timeout(8), .tmo_width(8)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack)
  );

  // Watchdog-disabled instance, driven only by the long-stall sequence
  wb_arb2_bram #(.timeout(0), .tmo_width(8)) dut_nowd (
    .clk_i(clk), .rst_i(rst_n),
    .m0_cyc_i(z_cyc), .m0_stb_i(z_stb), .m0_we_i(1'b0), .m0_adr_i(32'h80),
    .m0_dat_i(32'h0), .m0_sel_i(4'hF), .m0_dat_o(z_m0_rdat), .m0_ack_o(z_m0_ack),
    .m0_err_o(z_m0_err),
    .m1_cyc_i(1'b0), .m1_stb_i(1'b0), .m1_we_i(1'b0), .m1_adr_i(32'h0),
    .m1_dat_i(32'h0), .m1_sel_i(4'h0), .m1_dat_o(z_m1_rdat), .m1_ack_o(z_m1_ack),
    .m1_err_o(z_m1_err),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_adr_o(z_s_adr),
    .s_dat_o(z_s_wdat), .s_sel_o(z_s_sel), .s_dat_i(32'h0), .s_ack_i(1'b0)
  );

  // BlockRAM model: registered ack that toggles while stb is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_ack <= 1'b0;
    end else begin
      bram_ack <= 1'b0;
      if (s_cyc && s_stb && !bram_ack) begin
        bram_ack  <= 1'b1;
        bram_rdat <= mem[s_adr[11:2]];
        if (s_we)
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[11:2]][8*b +: 8] <= s_wdat[8*b +: 8];
      end
    end
  end

  assign s_ack  = direct ? d_ack : bram_ack;
  assign s_rdat = direct ? d_dat : bram_rdat;

  typedef struct {
    logic        c0, s0;
    logic [31:0] a0;
    logic        c1, s1;
    logic [31:0] a1;
    logic        ack;
    logic [31:0] sd;
    int          owner;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_cyc = v.c0; m0_stb = v.s0; m0_we = 1'b0; m0_adr = v.a0;
    m0_dat = 32'hA0A0_0000 ^ v.a0; m0_sel = 4'h3;
    m1_cyc = v.c1; m1_stb = v.s1; m1_we = 1'b1; m1_adr = v.a1;
    m1_dat = 32'hB0B0_0000 ^ v.a1; m1_sel = 4'hC;
    d_ack = v.ack; d_dat = v.sd;
  endtask

  task automatic driveMaster(input int id, input logic cyc, input logic [31:0] adr, input logic [31:0] dat);
    if (id == 0) begin
      m0_cyc = cyc; m0_stb = cyc; m0_we = cyc; m0_adr = adr; m0_dat = dat; m0_sel = 4'hF;
    end else begin
      m1_cyc = cyc; m1_stb = cyc; m1_we = cyc; m1_adr = adr; m1_dat = dat; m1_sel = 4'hF;
    end
  endtask

  // Entered at negedge+1; returns at negedge+1 of the ack cycle
  task automatic waitAck(input int id, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if ((id == 0) ? m0_ack : m1_ack) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) checkOutput($sformatf("m%0d_ack_timeout", id), 32'd0, 32'd1);
  endtask

  task automatic burstWrites(input int id, input logic [31:0] base, input logic [31:0] tag);
    bit ok;
    for (int k = 0; k < 4; k++) begin
      driveMaster(id, 1'b1, base + 32'(4 * k), tag + 32'(k));
      #1;
      waitAck(id, ok);
      if (ok) order_q.push_back(id);
      driveMaster(id, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    direct = 1'b1; d_ack = 1'b0; d_dat = 32'h0;
    z_cyc = 1'b0; z_stb = 1'b0;
    driveMaster(0, 1'b0, 32'h0, 32'h0);
    driveMaster(1, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    bit ok;
    bit seen_err;
    logic [31:0] exp_adr;

    vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,          0};
    vecs[1]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b1, 32'hDEADBEEF,   0};
    vecs[2]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,          1};
    vecs[3]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b1, 32'hCAFEF00D,   1};
    vecs[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0,          1};
    vecs[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 32'h20, 1'b1, 32'h11111111,   2};
    vecs[6]  = '{1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h20, 1'b0, 32'h0,          2};
    vecs[7]  = '{1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h00, 1'b1, 32'h22222222,   1};
    vecs[8]  = '{1'b0, 1'b0, 32'h14, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,          1};
    vecs[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h28, 1'b0, 32'h0,          0};
    vecs[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h28, 1'b0, 32'h0,          2};
    vecs[11] = '{1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h28, 1'b1, 32'h33333333,   2};
    vecs[12] = '{1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 32'h28, 1'b0, 32'h0,          2};
    vecs[13] = '{1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 32'h00, 1'b1, 32'h44444444,   1};
    vecs[14] = '{1'b0, 1'b0, 32'h18, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,          1};
    vecs[15] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,          0};

    // Reset values, with a live slave ack/data that must not leak through
    rst_n = 1'b0;
    direct = 1'b1; d_ack = 1'b1; d_dat = 32'h5A5A5A5A;
    z_cyc = 1'b0; z_stb = 1'b0;
    driveMaster(0, 1'b0, 32'h0, 32'h0);
    driveMaster(1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rst_s_cyc", 32'(s_cyc), 32'd0);
    checkOutput("rst_m0_ack", 32'(m0_ack), 32'd0);
    checkOutput("rst_m1_ack", 32'(m1_ack), 32'd0);
    checkOutput("rst_m0_dat", m0_rdat, 32'h0);
    checkOutput("rst_m1_dat", m1_rdat, 32'h0);
    checkOutput("rst_errs", {30'd0, m0_err, m1_err}, 32'd0);
    doReset();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      #1;
      case (vecs[i].owner)
        1: begin
          checkOutput($sformatf("v%0d_s_cyc", i), 32'(s_cyc), 32'(vecs[i].c0));
          checkOutput($sformatf("v%0d_s_stb", i), 32'(s_stb), 32'(vecs[i].s0));
          checkOutput($sformatf("v%0d_s_adr", i), s_adr, vecs[i].a0);
          checkOutput($sformatf("v%0d_s_dat", i), s_wdat, 32'hA0A0_0000 ^ vecs[i].a0);
          checkOutput($sformatf("v%0d_s_we_sel", i), {27'd0, s_we, s_sel}, 32'h03);
        end
        2: begin
          checkOutput($sformatf("v%0d_s_cyc", i), 32'(s_cyc), 32'(vecs[i].c1));
          checkOutput($sformatf("v%0d_s_stb", i), 32'(s_stb), 32'(vecs[i].s1));
          checkOutput($sformatf("v%0d_s_adr", i), s_adr, vecs[i].a1);
          checkOutput($sformatf("v%0d_s_dat", i), s_wdat, 32'hB0B0_0000 ^ vecs[i].a1);
          checkOutput($sformatf("v%0d_s_we_sel", i), {27'd0, s_we, s_sel}, 32'h1C);
        end
        default: begin
          checkOutput($sformatf("v%0d_s_bus", i), {29'd0, s_cyc, s_stb, s_we}, 32'd0);
          checkOutput($sformatf("v%0d_s_adr", i), s_adr, 32'h0);
        end
      endcase
      checkOutput($sformatf("v%0d_m0_ack", i), 32'(m0_ack), 32'(vecs[i].owner == 1 && vecs[i].ack));
      checkOutput($sformatf("v%0d_m1_ack", i), 32'(m1_ack), 32'(vecs[i].owner == 2 && vecs[i].ack));
      checkOutput($sformatf("v%0d_m0_dat", i), m0_rdat, (vecs[i].owner == 1) ? vecs[i].sd : 32'h0);
      checkOutput($sformatf("v%0d_m1_dat", i), m1_rdat, (vecs[i].owner == 2) ? vecs[i].sd : 32'h0);
      checkOutput($sformatf("v%0d_errs", i), {30'd0, m0_err, m1_err}, 32'd0);
      @(negedge clk);
    end

    // Round-robin: both masters start four write bursts on the same edge
    doReset();
    direct = 1'b0;
    order_q.delete();
    both_ack = 0;
    bursts_done = 1'b0;
    fork
      begin
        fork
          burstWrites(0, 32'h300, 32'hA000_0000);
          burstWrites(1, 32'h380, 32'hB000_0000);
        join
        bursts_done = 1'b1;
      end
      begin
        for (int n = 0; n < 400 && !bursts_done; n++) begin
          @(negedge clk);
          #2;
          if (m0_ack && m1_ack) both_ack++;
        end
      end
    join
    checkOutput("rr_both_ack_cycles", 32'(both_ack), 32'd0);
    checkOutput("rr_grant_count", 32'(order_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < order_q.size(); k++)
      checkOutput($sformatf("rr_grant_%0d", k), 32'(order_q[k]), 32'(k % 2));
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rr_mem_m0_%0d", k), mem[(12'h300 >> 2) + k], 32'hA000_0000 + 32'(k));
      checkOutput($sformatf("rr_mem_m1_%0d", k), mem[(12'h380 >> 2) + k], 32'hB000_0000 + 32'(k));
    end

    // m1 holds its cycle for three writes; m0 asks during the first and must wait
    doReset();
    direct = 1'b0;
    driveMaster(1, 1'b1, 32'h100, 32'h1111_0001);
    @(negedge clk);
    driveMaster(0, 1'b1, 32'h200, 32'h0D0D_0D0D);
    #1;
    checkOutput("ho_first_owner_adr", s_adr, 32'h100);
    for (int w = 0; w < 3; w++) begin
      waitAck(1, ok);
      checkOutput($sformatf("ho_m0_waits_%0d", w), 32'(m0_ack), 32'd0);
      if (w < 2) begin
        driveMaster(1, 1'b1, 32'h100 + 32'(4 * (w + 1)), 32'h1111_0002 + 32'(w));
        @(negedge clk);
        #1;
      end
    end
    driveMaster(1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("ho_no_idle_cyc", 32'(s_cyc), 32'd1);
    checkOutput("ho_no_idle_adr", s_adr, 32'h200);
    waitAck(0, ok);
    driveMaster(0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("ho_mem_w0", mem[12'h100 >> 2], 32'h1111_0001);
    checkOutput("ho_mem_w1", mem[12'h104 >> 2], 32'h1111_0002);
    checkOutput("ho_mem_w2", mem[12'h108 >> 2], 32'h1111_0003);
    checkOutput("ho_mem_m0", mem[12'h200 >> 2], 32'h0D0D_0D0D);

    // Watchdog at 8: err on the 9th granted stb cycle, again on the 18th; late ack there is dropped
    doReset();
    direct = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h40; m0_sel = 4'hF;
    #1;
    checkOutput("wd_idle_cyc", 32'(s_cyc), 32'd0);
    @(negedge clk);
    for (int i = 1; i <= 18; i++) begin
      d_ack = (i == 18);
      d_dat = 32'h77777777;
      #1;
      checkOutput($sformatf("wd_err_c%0d", i), 32'(m0_err), 32'(i == 9 || i == 18));
      checkOutput($sformatf("wd_stb_c%0d", i), 32'(s_stb), 32'(!(i == 9 || i == 18)));
      checkOutput($sformatf("wd_ack_c%0d", i), {30'd0, m0_ack, m1_err}, 32'd0);
      @(negedge clk);
    end
    d_ack = 1'b0;
    driveMaster(0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("wd_after_drop", {30'd0, m0_err, m0_ack}, 32'd0);

    // Watchdog disabled: a thousand stalled cycles never raise err
    doReset();
    z_cyc = 1'b1; z_stb = 1'b1;
    seen_err = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (z_m0_err || z_m1_err) seen_err = 1'b1;
    end
    checkOutput("nowd_err_seen", 32'(seen_err), 32'd0);
    checkOutput("nowd_stb_held", 32'(z_s_stb), 32'd1);
    z_cyc = 1'b0; z_stb = 1'b0;

    // Reset asserted mid-transfer while m1 owns the bus
    doReset();
    direct = 1'b1;
    driveMaster(1, 1'b1, 32'h60, 32'h6);
    @(negedge clk);
    #1;
    checkOutput("mr_gnt1_cyc", 32'(s_cyc), 32'd1);
    checkOutput("mr_gnt1_adr", s_adr, 32'h60);
    driveMaster(0, 1'b1, 32'h64, 32'h7);
    d_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_rst_cyc", 32'(s_cyc), 32'd0);
    checkOutput("mr_rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    checkOutput("mr_rst_errs", {30'd0, m0_err, m1_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d_ack = 1'b0;
    #1;
    checkOutput("mr_idle_cyc", 32'(s_cyc), 32'd0);
    @(negedge clk);
    #1;
    exp_adr = 32'h64;
    checkOutput("mr_tie_cyc", 32'(s_cyc), 32'd1);
    checkOutput("mr_tie_m0_wins", s_adr, exp_adr);
    driveMaster(0, 1'b0, 32'h0, 32'h0);
    driveMaster(1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
